// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I core: fetch/decode/execute/memory/writeback sequencing.
// Optional feature: define ILLEGAL_INSN_EN to trap unlisted opcodes in a sticky ILLEGAL state.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [6:0] op,
  input  logic       zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       RegWrite,
  output logic       instr_done,
  output logic [3:0] state,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  state_t state_q, state_d;
  logic   pc_update, branch, ir_wr, mem_wr, reg_wr, done;
  logic   gate;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    state_q <= S_FETCH;
    else if (run) state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    unique case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_IALU:      state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
`ifdef ILLEGAL_INSN_EN
          default:      state_d = S_ILLEGAL;
`else
          default:      state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ILLEGAL:  state_d = S_ILLEGAL;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    pc_update = 1'b0;
    branch    = 1'b0;
    ir_wr     = 1'b0;
    mem_wr    = 1'b0;
    reg_wr    = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        ir_wr     = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        pc_update = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_wr    = 1'b1;
        done      = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        mem_wr = 1'b1;
        done   = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      S_ALUWB: begin
        reg_wr = 1'b1;
        done   = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        branch  = 1'b1;
        done    = 1'b1;
      end
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
        reg_wr    = 1'b1;
        done      = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes fire only on an advancing cycle, so a stalled state issues them exactly once.
  assign gate       = run & ~reset;
  assign PCWrite    = gate & (pc_update | (branch & zero));
  assign IRWrite    = gate & ir_wr;
  assign MemWrite   = gate & mem_wr;
  assign RegWrite   = gate & reg_wr;
  assign instr_done = gate & done;
  assign state      = state_q;

`ifdef ILLEGAL_INSN_EN
  logic illegal_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                                     illegal_q <= 1'b0;
    else if (run && state_q == S_DECODE && state_d == S_ILLEGAL)   illegal_q <= 1'b1;
  end
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller: reset, per-opcode sequences, stalls, traps.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset, run, zero;
  logic [6:0] op;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [3:0] state;

  int errors = 0;
  int checks = 0;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .run(run), .op(op), .zero(zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .RegWrite(RegWrite), .instr_done(instr_done), .state(state), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] exp_s [5] = '{4'd0, 4'd1, 4'd6, 4'd8, 4'd0};
    int dones = 0;
    reset = 1'b1; run = 1'b1; op = 7'b0000011; zero = 1'b0;
    #3;
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL rst_state got=%0d exp=0", state); end
    checks++; if (IRWrite !== 1'b0 || PCWrite !== 1'b0) begin errors++; $display("FAIL rst_strobes got IR=%b PC=%b exp 0", IRWrite, PCWrite); end
    checks++; if (ALUSrcB !== 2'b10 || ResultSrc !== 2'b10) begin errors++; $display("FAIL rst_selects got B=%b R=%b exp 10/10", ALUSrcB, ResultSrc); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL rst_illegal got=%b exp=0", illegal); end
    tick();
    reset = 1'b0;
    tick(); tick(); tick();
    checks++; if (state !== 4'd3 || AdrSrc !== 1'b1) begin errors++; $display("FAIL pre_rst_memread got st=%0d adr=%b exp 3/1", state, AdrSrc); end
    #2 reset = 1'b1;
    #1;
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL async_rst_state got=%0d exp=0", state); end
    checks++; if (IRWrite !== 1'b0 || instr_done !== 1'b0) begin errors++; $display("FAIL async_rst_strobes got IR=%b done=%b exp 0", IRWrite, instr_done); end
    checks++; if (ALUSrcB !== 2'b10) begin errors++; $display("FAIL async_rst_srcb got=%b exp=10", ALUSrcB); end
    tick();
    reset = 1'b0; op = 7'b0110011;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (state !== exp_s[i]) begin errors++; $display("FAIL rst_seq_state[%0d] got=%0d exp=%0d", i, state, exp_s[i]); end
      checks++; if (RegWrite !== (i == 3)) begin errors++; $display("FAIL rst_seq_regwrite[%0d] got=%b exp=%b", i, RegWrite, (i == 3)); end
      if (instr_done === 1'b1) dones++;
      if (i < 4) tick();
    end
    checks++; if (dones !== 1) begin errors++; $display("FAIL rst_seq_done_count got=%0d exp=1", dones); end
  endtask

  task automatic test_lw();
    logic [3:0] exp_s [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    op = 7'b0000011; run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (state !== exp_s[i]) begin errors++; $display("FAIL lw_state[%0d] got=%0d exp=%0d", i, state, exp_s[i]); end
      checks++; if (AdrSrc !== (i == 3)) begin errors++; $display("FAIL lw_adrsrc[%0d] got=%b exp=%b", i, AdrSrc, (i == 3)); end
      checks++; if (RegWrite !== (i == 4)) begin errors++; $display("FAIL lw_regwrite[%0d] got=%b exp=%b", i, RegWrite, (i == 4)); end
      if (i == 2) begin
        checks++; if (ALUSrcA !== 2'b10 || ALUSrcB !== 2'b01) begin errors++; $display("FAIL lw_memadr_sel got A=%b B=%b exp 10/01", ALUSrcA, ALUSrcB); end
      end
      if (i == 4) begin
        checks++; if (ResultSrc !== 2'b01 || instr_done !== 1'b1) begin errors++; $display("FAIL lw_memwb got R=%b done=%b exp 01/1", ResultSrc, instr_done); end
      end
      tick();
    end
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL lw_return got=%0d exp=0", state); end
  endtask

  task automatic test_sw();
    logic [3:0] exp_s [4] = '{4'd0, 4'd1, 4'd2, 4'd5};
    int mw = 0, rw = 0;
    op = 7'b0100011; run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (state !== exp_s[i]) begin errors++; $display("FAIL sw_state[%0d] got=%0d exp=%0d", i, state, exp_s[i]); end
      if (MemWrite === 1'b1) mw++;
      if (RegWrite === 1'b1) rw++;
      tick();
    end
    checks++; if (mw !== 1 || rw !== 0) begin errors++; $display("FAIL sw_strobes got mw=%0d rw=%0d exp 1/0", mw, rw); end
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL sw_return got=%0d exp=0", state); end
  endtask

  task automatic test_beq();
    logic [3:0] exp_s [3] = '{4'd0, 4'd1, 4'd9};
    op = 7'b1100011; run = 1'b1;
    for (int z = 1; z >= 0; z--) begin
      zero = z[0];
      for (int i = 0; i < 3; i++) begin
        #1;
        checks++; if (state !== exp_s[i]) begin errors++; $display("FAIL beq%0d_state[%0d] got=%0d exp=%0d", z, i, state, exp_s[i]); end
        if (i == 2) begin
          checks++; if (PCWrite !== z[0]) begin errors++; $display("FAIL beq%0d_pcwrite got=%b exp=%b", z, PCWrite, z[0]); end
          checks++; if (ALUOp !== 2'b01 || instr_done !== 1'b1) begin errors++; $display("FAIL beq%0d_aluop got op=%b done=%b exp 01/1", z, ALUOp, instr_done); end
        end
        tick();
      end
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL beq%0d_return got=%0d exp=0", z, state); end
    end
    zero = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_s [8] = '{4'd0, 4'd1, 4'd6, 4'd8, 4'd0, 4'd1, 4'd7, 4'd8};
    run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) op = 7'b0110011;
      if (i == 4) op = 7'b0010011;
      #1;
      checks++; if (state !== exp_s[i]) begin errors++; $display("FAIL b2b_state[%0d] got=%0d exp=%0d", i, state, exp_s[i]); end
      if (i == 1) begin
        checks++; if (ALUSrcA !== 2'b01 || ALUSrcB !== 2'b01) begin errors++; $display("FAIL b2b_decode_sel got A=%b B=%b exp 01/01", ALUSrcA, ALUSrcB); end
      end
      if (i == 2) begin
        checks++; if (ALUOp !== 2'b10 || ALUSrcB !== 2'b00) begin errors++; $display("FAIL b2b_execr got op=%b B=%b exp 10/00", ALUOp, ALUSrcB); end
      end
      if (i == 6) begin
        checks++; if (ALUOp !== 2'b10 || ALUSrcB !== 2'b01) begin errors++; $display("FAIL b2b_execi got op=%b B=%b exp 10/01", ALUOp, ALUSrcB); end
      end
      tick();
    end
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL b2b_return got=%0d exp=0", state); end
  endtask

  task automatic test_stall_jal();
    logic [3:0] exp_s [6] = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd10, 4'd0};
    logic       runs  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    int pcw = 0;
    op = 7'b1101111;
    for (int i = 0; i < 6; i++) begin
      run = runs[i];
      #1;
      checks++; if (state !== exp_s[i]) begin errors++; $display("FAIL jal_state[%0d] got=%0d exp=%0d", i, state, exp_s[i]); end
      if (i < 5 && PCWrite === 1'b1) pcw++;
      if (i == 4) begin
        checks++; if (RegWrite !== 1'b1 || instr_done !== 1'b1) begin errors++; $display("FAIL jal_wb got rw=%b done=%b exp 1/1", RegWrite, instr_done); end
      end
      if (i < 5) tick();
    end
    checks++; if (pcw !== 2) begin errors++; $display("FAIL jal_pcwrite_count got=%0d exp=2", pcw); end
  endtask

  task automatic test_illegal();
    op = 7'b1111111; run = 1'b1;
    #1;
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL ill_start got=%0d exp=0", state); end
    tick();
    checks++; if (state !== 4'd1 || instr_done !== 1'b0) begin errors++; $display("FAIL ill_decode got st=%0d done=%b exp 1/0", state, instr_done); end
    tick();
`ifdef ILLEGAL_INSN_EN
    checks++; if (state !== 4'd11 || illegal !== 1'b1) begin errors++; $display("FAIL ill_trap got st=%0d ill=%b exp 11/1", state, illegal); end
    op = 7'b0110011;
    tick(); tick();
    checks++; if (state !== 4'd11 || illegal !== 1'b1) begin errors++; $display("FAIL ill_hold got st=%0d ill=%b exp 11/1", state, illegal); end
    checks++; if (PCWrite !== 1'b0 || IRWrite !== 1'b0 || RegWrite !== 1'b0 || instr_done !== 1'b0) begin errors++; $display("FAIL ill_strobes got pc=%b ir=%b rw=%b done=%b exp 0", PCWrite, IRWrite, RegWrite, instr_done); end
    reset = 1'b1;
    #1;
    checks++; if (state !== 4'd0 || illegal !== 1'b0) begin errors++; $display("FAIL ill_reset got st=%0d ill=%b exp 0/0", state, illegal); end
    reset = 1'b0;
`else
    checks++; if (state !== 4'd0 || illegal !== 1'b0) begin errors++; $display("FAIL ill_nop got st=%0d ill=%b exp 0/0", state, illegal); end
`endif
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_beq();
    test_back_to_back();
    test_stall_jal();
    test_illegal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control FSM for the multicycle RV32I core. It sequences each instruction through fetch, decode, execute, memory and writeback states. It drives the datapath's mux selects and write strobes, and supplies the 2-bit ALUOp that `alu_decoder` expands into ALUControl. The block sits beside the datapath and reads the instruction register opcode and the ALU Zero flag.

## Interface
Parameters:
- none

Ports:
- `clk` input 1: single core clock, rising-edge.
- `reset` input 1: asynchronous, active-high reset.
- `run` input 1: advance enable. When 0, the state is held and all strobes are 0.
- `op` input 7: instr[6:0] from the instruction register.
- `zero` input 1: ALU Zero flag.
- `PCWrite` output 1: PC register enable.
- `AdrSrc` output 1: memory address select. 0 = PC, 1 = ALUOut.
- `MemWrite` output 1: data memory write strobe.
- `IRWrite` output 1: instruction/OldPC register enable.
- `ResultSrc` output 2: result mux select. 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ALUSrcA` output 2: ALU A select. 00 = PC, 01 = OldPC, 10 = rs1.
- `ALUSrcB` output 2: ALU B select. 00 = rs2, 01 = ImmExt, 10 = const 4.
- `ALUOp` output 2: to `alu_decoder`. 00 = add, 01 = sub, 10 = funct-decoded.
- `RegWrite` output 1: register file write strobe.
- `instr_done` output 1: one-cycle pulse in the last state of each instruction.
- `state` output 4: current state, for debug and bench observation.
- `illegal` output 1: sticky illegal-opcode flag. Present only under ILLEGAL_INSN_EN; otherwise tied 0.

## Operation
State encoding:
- FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10, ILLEGAL=11.

Opcodes decoded in DECODE:
- lw 0000011, sw 0100011 → MEMADR
- R-type 0110011 → EXECUTER
- I-ALU 0010011 → EXECUTEI
- beq 1100011 → BEQ
- jal 1101111 → JAL

Transitions:
- FETCH → DECODE
- MEMADR → MEMREAD (lw) or MEMWRITE (sw)
- MEMREAD → MEMWB
- EXECUTER and EXECUTEI → ALUWB
- MEMWB, MEMWRITE, ALUWB, BEQ, JAL → FETCH

Moore outputs; every signal not listed is 0:
- FETCH: IRWrite=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target precompute).
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
- MEMREAD: AdrSrc=1, ResultSrc=00.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- ALUWB: ResultSrc=00, RegWrite=1.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1, RegWrite=1.

Derived signals:
- PCWrite = PCUpdate | (Branch & zero). This is combinational from the live `zero` input.
- instr_done = 1 in MEMWB, MEMWRITE, ALUWB, BEQ and JAL.
- Strobes PCWrite, IRWrite, MemWrite and RegWrite are ANDed with `run` and with !reset.
- Mux selects and ALUOp are not gated by `run`.

## Timing
- Reset (asynchronous): state=FETCH immediately.
  - While reset is high, all strobes are 0 and instr_done=0.
  - Selects show the FETCH values.
  - illegal is cleared.
- Reset deasserted mid-instruction: the instruction is abandoned, with no partial strobe. The first edge with run=1 after release executes FETCH.
- State register updates on the rising clk edge only when run=1.
- Cycles per instruction:
  - lw = 5
  - sw = 4
  - R-type and I-ALU = 4
  - beq = 3
  - jal = 3
- Back-to-back instructions: FETCH directly follows the terminal state, with no bubble.
- run=0 for N cycles stretches the current state by N cycles. The state's strobes are issued exactly once, on the cycle run=1.
- beq not taken (zero=0): PCWrite stays 0 in BEQ and the state still returns to FETCH.

## Configuration
Macro: ILLEGAL_INSN_EN.
- **Defined:** any unlisted opcode in DECODE → ILLEGAL.
  - ILLEGAL is a terminal trap: all strobes 0, selects at their zero defaults.
  - `illegal` is set sticky and is cleared only by reset.
- **Undefined:** an unlisted opcode in DECODE → FETCH, so the instruction is a 2-cycle no-op with instr_done=0. `illegal` is tied 0 and the ILLEGAL state code is unused.

## Test plan
- Reset high mid-MEMREAD, then released with run=1, op=0110011 → state=0 asynchronously. Strobes stay 0 during reset. Sequence is 0,1,6,8,0; RegWrite=1 only in state 8; instr_done pulses once.
- lw (op=0000011) → states 0,1,2,3,4. AdrSrc=1 in state 3. ResultSrc=01 and RegWrite=1 in state 4. 5 cycles total.
- sw (op=0100011) → states 0,1,2,5. MemWrite=1 for exactly one cycle. RegWrite never 1.
- beq with zero=1, then a second beq with zero=0 → PCWrite=1 in BEQ for the first only. ALUOp=01 in both. Each takes 3 cycles.
- jal (op=1101111) with run toggling 1,0,0,1 in DECODE → state 1 is held 3 cycles. PCWrite pulses once in FETCH and once in JAL; RegWrite=1 in JAL.
- op=1111111 → with ILLEGAL_INSN_EN: state=11, illegal=1, held until reset. Without it: state returns to 0 and illegal=0.
